// File: rtl/cache_mem_arbiter.sv
// Shared RAM port arbiter for the icache and dcache. A grant is held across multi-word transfers.
// Optional fairness (round-robin tie-break plus a burst cap) is compiled in with CACHE_ARB_FAIR_EN.
module cache_mem_arbiter #(
   parameter int BURST_MAX = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic [1:0]  grant,
   output logic        ram_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISERV = 2'b01,
      DSERV = 2'b10
   } state_t;

   localparam logic [1:0] RAM_ACCESS = 2'b10;
   localparam logic [1:0] RAM_ERROR  = 2'b11;

   if (BURST_MAX < 1) begin : g_burst_max_check
      $error("BURST_MAX must be at least 1");
   end

   state_t state;
   logic   i_req;
   logic   d_req;
   logic   access;

   assign i_req  = iREN;
   assign d_req  = dREN | dWEN;
   assign access = (ramstate == RAM_ACCESS);
   assign grant  = state;

`ifdef CACHE_ARB_FAIR_EN
   localparam int BCNT_W = $clog2(BURST_MAX + 1);

   logic [BCNT_W-1:0] bcnt;
   logic              last_d;
   logic              cap_hit;

   // Saturating compare so a peer arriving after a long run still forces a yield.
   assign cap_hit = (int'(bcnt) + 1 >= BURST_MAX);
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         ram_err <= 1'b0;
`ifdef CACHE_ARB_FAIR_EN
         bcnt    <= '0;
         last_d  <= 1'b0;
`endif
      end else begin
         if (state != IDLE && ramstate == RAM_ERROR)
            ram_err <= 1'b1;
         case (state)
            IDLE: begin
`ifdef CACHE_ARB_FAIR_EN
               bcnt <= '0;
               if (d_req && i_req)
                  state <= last_d ? ISERV : DSERV;
               else if (d_req)
                  state <= DSERV;
               else if (i_req)
                  state <= ISERV;
`else
               if (d_req)
                  state <= DSERV;
               else if (i_req)
                  state <= ISERV;
`endif
            end
            DSERV: begin
`ifdef CACHE_ARB_FAIR_EN
               last_d <= 1'b1;
               if (!d_req) begin
                  state <= IDLE;
                  bcnt  <= '0;
               end else if (access) begin
                  if (cap_hit && i_req) begin
                     state <= ISERV;
                     bcnt  <= '0;
                  end else if (int'(bcnt) < BURST_MAX) begin
                     bcnt <= bcnt + 1'b1;
                  end
               end
`else
               if (!d_req)
                  state <= IDLE;
`endif
            end
            ISERV: begin
`ifdef CACHE_ARB_FAIR_EN
               last_d <= 1'b0;
               if (!i_req) begin
                  state <= IDLE;
                  bcnt  <= '0;
               end else if (access) begin
                  if (cap_hit && d_req) begin
                     state <= DSERV;
                     bcnt  <= '0;
                  end else if (int'(bcnt) < BURST_MAX) begin
                     bcnt <= bcnt + 1'b1;
                  end
               end
`else
               if (!i_req)
                  state <= IDLE;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ERROR is never ACCESS, so the owner's wait stays high and it simply retries.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iload    = '0;
      dload    = '0;
      iwait    = i_req;
      dwait    = d_req;
      if (!RST) begin
         case (state)
            DSERV: begin
               ramaddr  = daddr;
               ramstore = dstore;
               dload    = ramload;
               dwait    = !access;
               if (dWEN)
                  ramWEN = 1'b1;
               else
                  ramREN = dREN;
            end
            ISERV: begin
               ramaddr = iaddr;
               ramREN  = iREN;
               iload   = ramload;
               iwait   = !access;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed handshake checks, then random cache traffic against
// a word-memory reference model with a queue scoreboard.
module tb_cache_mem_arbiter;

   localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;
   localparam int NOPS = 40;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
   logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
   logic        iwait, dwait, ramREN, ramWEN, ram_err;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate, grant;

   logic        ram_auto = 1'b0;
   logic        sb_en = 1'b0;
   logic [1:0]  rs_d = FREE, rs_m = FREE;
   logic [31:0] rl_d = '0, rl_m = '0;
   assign ramstate = ram_auto ? rs_m : rs_d;
   assign ramload  = ram_auto ? rl_m : rl_d;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        iq[$];
   exp_t        dq[$];
   logic [31:0] ram_mem[logic [31:0]];
   logic [31:0] ref_mem[logic [31:0]];
   logic        i_done = 1'b0, d_done = 1'b0;

   cache_mem_arbiter #(.BURST_MAX(2)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .grant(grant), .ram_err(ram_err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #600000;
      $display("FAIL watchdog expired: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   // RAM model: random BUSY latency, occasional ERROR before completing.
   int  busy_left = 0;
   bit  in_op = 0;
   always @(negedge CLK) begin
      if (ram_auto) begin
         if (RST || !(ramREN || ramWEN)) begin
            rs_m  = FREE;
            in_op = 0;
         end else begin
            if (!in_op) begin
               in_op     = 1;
               busy_left = $urandom_range(0, 2);
            end
            if (busy_left > 0) begin
               busy_left--;
               rs_m = BUSY;
            end else if ($urandom_range(0, 9) == 0) begin
               rs_m = ERROR;
            end else begin
               rs_m = ACCESS;
               if (ramWEN) begin
                  ram_mem[ramaddr] = ramstore;
                  rl_m = $urandom;
               end else begin
                  rl_m = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : init_val(ramaddr);
               end
               in_op = 0;
            end
         end
      end
   end

   // Scoreboard monitor: pops whenever a cache sees its wait fall.
   always @(negedge CLK) begin
      if (sb_en) begin
         exp_t e;
         #2;
         if (!RST) begin
            if (iREN && !iwait) begin
               if (iq.size() == 0) begin
                  chk("i_unexpected_completion", 32'd1, 32'd0);
               end else begin
                  e = iq.pop_front();
                  chk("iload", iload, e.data);
                  chk("i_ramaddr", ramaddr, e.addr);
                  chk("i_ramwen", {31'd0, ramWEN}, 32'd0);
               end
               i_done = 1'b1;
            end
            if ((dREN || dWEN) && !dwait) begin
               if (dq.size() == 0) begin
                  chk("d_unexpected_completion", 32'd1, 32'd0);
               end else begin
                  e = dq.pop_front();
                  chk("d_ramaddr", ramaddr, e.addr);
                  chk("d_ramwen", {31'd0, ramWEN}, {31'd0, e.we});
                  if (e.we)
                     chk("d_ramstore", ramstore, e.data);
                  else
                     chk("dload", dload, e.data);
               end
               d_done = 1'b1;
            end
            if (ramREN && ramWEN)
               chk("strobe_exclusive", 32'd1, 32'd0);
         end
      end
   end

   task automatic i_driver();
      for (int n = 0; n < NOPS; n++) begin
         int   gap;
         int   t;
         exp_t e;
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            iREN = 1'b0;
            repeat (gap) tick();
         end
         e.we   = 1'b0;
         e.addr = 32'($urandom_range(0, 63)) * 4;
         e.data = ref_read(e.addr);
         iaddr  = e.addr;
         iREN   = 1'b1;
         i_done = 1'b0;
         iq.push_back(e);
         t = 0;
         do begin
            tick();
            t++;
         end while (!i_done && t < 3000);
         if (!i_done) chk("i_timeout", 32'd1, 32'd0);
      end
      iREN = 1'b0;
   endtask

   task automatic d_driver();
      for (int n = 0; n < NOPS; n++) begin
         int   gap;
         int   t;
         exp_t e;
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            dREN = 1'b0;
            dWEN = 1'b0;
            repeat (gap) tick();
         end
         e.addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
         e.we   = ($urandom_range(0, 2) == 0);
         if (e.we) begin
            e.data = $urandom;
            ref_mem[e.addr] = e.data;
            dWEN   = 1'b1;
            dREN   = 1'($urandom_range(0, 1));
            dstore = e.data;
         end else begin
            e.data = ref_read(e.addr);
            dWEN   = 1'b0;
            dREN   = 1'b1;
            dstore = $urandom;
         end
         daddr  = e.addr;
         d_done = 1'b0;
         dq.push_back(e);
         t = 0;
         do begin
            tick();
            t++;
         end while (!d_done && t < 3000);
         if (!d_done) chk("d_timeout", 32'd1, 32'd0);
      end
      dREN = 1'b0;
      dWEN = 1'b0;
   endtask

   initial begin
      // Reset: strobes and data outputs forced low, waits follow requests.
      tick();
      iREN = 1'b1; dREN = 1'b1; daddr = 32'h55; dstore = 32'h77;
      rs_d = ACCESS; rl_d = 32'hDEAD;
      settle();
      chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
      chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
      chk("rst_ramaddr", ramaddr, 32'd0);
      chk("rst_dload", dload, 32'd0);
      chk("rst_iwait", {31'd0, iwait}, 32'd1);
      chk("rst_dwait", {31'd0, dwait}, 32'd1);
      tick();
      chk("rst_grant", {30'd0, grant}, 32'd0);
      chk("rst_ram_err", {31'd0, ram_err}, 32'd0);
      RST = 1'b0; iREN = 1'b0; dREN = 1'b0; rs_d = FREE;
      tick();

      // icache read with two BUSY cycles.
      iREN = 1'b1; iaddr = 32'h40;
      settle();
      chk("a_idle_iwait", {31'd0, iwait}, 32'd1);
      chk("a_idle_ramREN", {31'd0, ramREN}, 32'd0);
      tick();
      rs_d = BUSY;
      settle();
      chk("a_grant", {30'd0, grant}, 32'd1);
      chk("a_ramREN", {31'd0, ramREN}, 32'd1);
      chk("a_ramaddr", ramaddr, 32'h40);
      chk("a_busy_iwait", {31'd0, iwait}, 32'd1);
      tick();
      settle();
      chk("a_busy2_iwait", {31'd0, iwait}, 32'd1);
      tick();
      rs_d = ACCESS; rl_d = 32'h1234;
      settle();
      chk("a_access_iwait", {31'd0, iwait}, 32'd0);
      chk("a_iload", iload, 32'h1234);
      chk("a_ramWEN", {31'd0, ramWEN}, 32'd0);
      tick();
      iREN = 1'b0; rs_d = FREE;
      tick();
      settle();
      chk("a_release_grant", {30'd0, grant}, 32'd0);

      // Simultaneous requests, dcache two-word fill while icache waits.
      dREN = 1'b1; iREN = 1'b1; daddr = 32'h100; iaddr = 32'h44;
      tick();
      rs_d = ACCESS; rl_d = 32'hA0;
      settle();
      chk("b_dfirst_grant", {30'd0, grant}, 32'd2);
      chk("b_w0_dwait", {31'd0, dwait}, 32'd0);
      chk("b_w0_dload", dload, 32'hA0);
      chk("b_w0_iwait", {31'd0, iwait}, 32'd1);
      tick();
      daddr = 32'h104; rl_d = 32'hA4;
      settle();
      chk("b_w1_grant", {30'd0, grant}, 32'd2);
      chk("b_w1_ramaddr", ramaddr, 32'h104);
      chk("b_w1_dwait", {31'd0, dwait}, 32'd0);
      chk("b_w1_iwait", {31'd0, iwait}, 32'd1);
      tick();
      daddr = 32'h108; rs_d = FREE;
      settle();
`ifdef CACHE_ARB_FAIR_EN
      chk("b_yield_grant", {30'd0, grant}, 32'd1);
      chk("b_yield_bcnt", 32'(dut.bcnt), 32'd0);
      chk("b_yield_ramaddr", ramaddr, 32'h44);
      chk("b_yield_dwait", {31'd0, dwait}, 32'd1);
`else
      chk("b_hold_grant", {30'd0, grant}, 32'd2);
      chk("b_hold_iwait", {31'd0, iwait}, 32'd1);
      chk("b_hold_ramaddr", ramaddr, 32'h108);
`endif
      tick();
      dREN = 1'b0;
      settle();
`ifdef CACHE_ARB_FAIR_EN
      chk("b_i_grant", {30'd0, grant}, 32'd1);
`else
      chk("b_drop_grant", {30'd0, grant}, 32'd2);
      chk("b_drop_iwait", {31'd0, iwait}, 32'd1);
      chk("b_drop_ramREN", {31'd0, ramREN}, 32'd0);
`endif
      tick();
      iREN = 1'b0;
      tick();
      settle();
      chk("b_end_grant", {30'd0, grant}, 32'd0);

      // dcache write (dWEN wins), with one ERROR before ACCESS.
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hCAFE;
      tick();
      rs_d = BUSY;
      settle();
      chk("c_ramWEN", {31'd0, ramWEN}, 32'd1);
      chk("c_ramREN", {31'd0, ramREN}, 32'd0);
      chk("c_ramaddr", ramaddr, 32'h80);
      chk("c_ramstore", ramstore, 32'hCAFE);
      tick();
      rs_d = ERROR;
      settle();
      chk("c_err_dwait", {31'd0, dwait}, 32'd1);
      tick();
      rs_d = ACCESS;
      settle();
      chk("c_ram_err_set", {31'd0, ram_err}, 32'd1);
      chk("c_access_dwait", {31'd0, dwait}, 32'd0);
      tick();
      dREN = 1'b0; dWEN = 1'b0; rs_d = FREE;
      tick();
      tick();
      settle();
      chk("c_ram_err_sticky", {31'd0, ram_err}, 32'd1);

      // Reset during the second word of a dcache fill.
      dREN = 1'b1; daddr = 32'h300;
      tick();
      rs_d = ACCESS; rl_d = 32'h11;
      tick();
      daddr = 32'h304; rs_d = BUSY; RST = 1'b1;
      settle();
      chk("d_rst_ramREN", {31'd0, ramREN}, 32'd0);
      tick();
      RST = 1'b0; rs_d = FREE;
      settle();
      chk("d_rst_grant", {30'd0, grant}, 32'd0);
      chk("d_rst_ramREN_after", {31'd0, ramREN}, 32'd0);
      chk("d_rst_ramWEN_after", {31'd0, ramWEN}, 32'd0);
      chk("d_rst_ram_err_clr", {31'd0, ram_err}, 32'd0);
      tick();
      settle();
      chk("d_regrant", {30'd0, grant}, 32'd2);
      chk("d_regrant_ramaddr", ramaddr, 32'h304);
      dREN = 1'b0;
      tick();
      tick();

      // Random traffic against the reference memory.
      ram_auto = 1'b1;
      sb_en    = 1'b1;
      fork
         i_driver();
         d_driver();
      join
      repeat (4) tick();
      chk("iq_drained", 32'(iq.size()), 32'd0);
      chk("dq_drained", 32'(dq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
